mi_operand_loader: RTL

MI_OPERAND_LOADER -- requirements
Module: mi_operand_loader

---
 rtl/mi_operand_loader_if.sv | 13 +
 rtl/mi_operand_loader.sv | 91 +++++++++
 2 files changed

// File: rtl/mi_operand_loader_if.sv
// mi_operand_loader_if: operand upload stream and modular-inverse engine handshake bundle
interface mi_operand_loader_if #(parameter int K = 128);
  logic s_valid, s_ready, s_last;
  logic [K-1:0] s_data;
  logic mi_start, mi_valid_in, mi_valid_out;
  logic [K-1:0] mi_a, mi_p;
  logic busy, err;
  logic [1:0] err_code;
  modport master (output s_valid, s_data, s_last, mi_valid_out,
                  input s_ready, mi_start, mi_valid_in, mi_a, mi_p, busy, err, err_code);
  modport slave (input s_valid, s_data, s_last, mi_valid_out,
                 output s_ready, mi_start, mi_valid_in, mi_a, mi_p, busy, err, err_code);
endinterface

// File: rtl/mi_operand_loader.sv
// mi_operand_loader: buffers a and p operands, validates them, then streams both to the inverse engine
module mi_operand_loader #(
  parameter int K = 128,
  parameter int N = 32
) (
  input logic clk,
  input logic rst_n,
  mi_operand_loader_if.slave bus
);
  localparam int ADDR_W = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(2 * N);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, CHECK = 3'd2, START = 3'd3,
                         STREAM = 3'd4, WAIT = 3'd5, ERROR = 3'd6;
  logic [2:0] state, nxt;
  logic [CW-1:0] cnt;
  logic [1:0] code, nxt_code;
  logic live, a_nz, p_nz, p_odd, acc, last_word, frame_err, in_a, strm;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [K-1:0] a_mem [N];
  logic [K-1:0] p_mem [N];
  logic [K-1:0] a_q, p_q;
  // live keeps s_ready low until the first edge after reset release
  assign bus.s_ready = live && (state == IDLE || state == LOAD);
  assign acc = bus.s_valid && bus.s_ready;
  assign last_word = cnt == CW'(2 * N - 1);
  assign frame_err = bus.s_last != last_word;
  assign in_a = cnt < CW'(N);
  assign wr_addr = ADDR_W'(in_a ? cnt : cnt - CW'(N));
  assign strm = state == STREAM;
  // read one word ahead so the buffer latency hides behind START
  assign rd_addr = strm ? ADDR_W'(cnt + 1'b1) : '0;
  always_comb begin
    nxt = state;
    nxt_code = code;
    case (state)
      IDLE, LOAD: if (acc) begin
        nxt = frame_err ? ERROR : last_word ? CHECK : LOAD;
        nxt_code = frame_err ? 2'b01 : 2'b00;
      end
      CHECK: begin
        nxt = (!p_odd || !p_nz || !a_nz) ? ERROR : START;
        nxt_code = (!p_odd || !p_nz) ? 2'b10 : !a_nz ? 2'b11 : code;
      end
      START: nxt = STREAM;
      STREAM: if (cnt == CW'(N - 1)) nxt = WAIT;
      WAIT: if (bus.mi_valid_out) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      code <= 2'b00;
      live <= 1'b0;
      a_nz <= 1'b0;
      p_nz <= 1'b0;
      p_odd <= 1'b0;
    end else begin
      live <= 1'b1;
      state <= nxt;
      code <= nxt_code;
      if (acc) begin
        cnt <= cnt + 1'b1;
        a_nz <= a_nz | (in_a && |bus.s_data);
        p_nz <= p_nz | (!in_a && |bus.s_data);
        if (cnt == CW'(N)) p_odd <= bus.s_data[0];
      end else if (state == START) cnt <= '0;
      else if (strm) cnt <= cnt + 1'b1;
      if (nxt == IDLE) begin
        cnt <= '0;
        a_nz <= 1'b0;
        p_nz <= 1'b0;
        p_odd <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (acc && in_a) a_mem[wr_addr] <= bus.s_data;
    if (acc && !in_a) p_mem[wr_addr] <= bus.s_data;
    a_q <= a_mem[rd_addr];
    p_q <= p_mem[rd_addr];
  end
  assign bus.mi_start = state == START;
  assign bus.mi_valid_in = strm;
  assign bus.mi_a = strm ? a_q : '0;
  assign bus.mi_p = strm ? p_q : '0;
  assign bus.busy = state != IDLE;
  assign bus.err = state == ERROR;
  assign bus.err_code = code;
endmodule
